run_controller: RTL and testbench

Sequences execution of the simple CPU for bench and FPGA runs. Holds the core in reset until commanded, then releases it for free-running or single-step execution. Counts enabled cycles and stops the core on halt or on a cycle budget. Latches the program return value and exit status so a bench or host interface can read them.

---
 rtl/run_controller.sv | 77 +++++++
 tb/tb_run_controller.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// run_controller: sequences core reset release, free-run/single-step execution,
// cycle budgeting and result latching for bench and FPGA runs.
module run_controller #(
  parameter int MAX_CYCLES = 500000,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             cpu_halt,
  input  logic [15:0]      ret_val,
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             timed_out,
  output logic [7:0]       result,
  output logic [CNT_W-1:0] cycle_count
);
  localparam int HW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, RESET_HOLD, RUN, STEP_WAIT, STEP_EXEC, DONE} state_t;
  state_t state;
  logic [HW-1:0] hold_cnt;
  logic last, unused_ret;
  assign unused_ret = ^ret_val[15:8];
  assign last = cycle_count == CNT_W'(MAX_CYCLES - 1);
  assign cpu_rst = state == IDLE || state == RESET_HOLD;
  assign cpu_en = state == RUN || state == STEP_EXEC;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold_cnt <= '0;
      halted <= 1'b0;
      timed_out <= 1'b0;
      result <= '0;
      cycle_count <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else if (start && (state == IDLE || state == DONE)) begin
      state <= RESET_HOLD;
      hold_cnt <= '0;
      halted <= 1'b0;
      timed_out <= 1'b0;
      result <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        RESET_HOLD:
          if (hold_cnt == HW'(RST_CYCLES - 1)) state <= step_mode ? STEP_WAIT : RUN;
          else hold_cnt <= hold_cnt + 1'b1;
        RUN, STEP_EXEC: begin
          // halt beats timeout when both land on the same enabled cycle
          cycle_count <= (cycle_count == CNT_W'(MAX_CYCLES)) ? cycle_count : cycle_count + 1'b1;
          if (cpu_halt) begin
            state <= DONE;
            halted <= 1'b1;
            result <= ret_val[7:0];
          end else if (last) begin
            state <= DONE;
            timed_out <= 1'b1;
          end else begin
            state <= step_mode ? STEP_WAIT : RUN;
          end
        end
        STEP_WAIT: state <= step_req ? STEP_EXEC : (step_mode ? STEP_WAIT : RUN);
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed test-plan scenarios plus randomized traffic,
// checked every cycle against a run-level behavioural model.
module tb_run_controller;
  localparam int MAX = 16;
  localparam int RST = 2;
  logic clk = 0, rst_n = 0;
  logic start = 0, abort = 0, step_mode = 0, step_req = 0, cpu_halt = 0;
  logic [15:0] ret_val = 0;
  logic cpu_rst, cpu_en, busy, done, halted, timed_out;
  logic [7:0] result;
  logic [31:0] cycle_count;
  int total = 0, bad = 0;
  run_controller #(.MAX_CYCLES(MAX), .RST_CYCLES(RST), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .step_mode(step_mode),
    .step_req(step_req), .cpu_halt(cpu_halt), .ret_val(ret_val), .cpu_rst(cpu_rst),
    .cpu_en(cpu_en), .busy(busy), .done(done), .halted(halted), .timed_out(timed_out),
    .result(result), .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  // model: a run is active or finished; during a run the core is either in its
  // reset hold, executing this cycle, or idling until a step is granted
  int m_hold = 0, m_cnt = 0;
  bit m_act = 0, m_fin = 0, m_en = 0, m_hlt = 0, m_to = 0;
  logic [7:0] m_res = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 0; m_cnt = 0; m_act = 0; m_fin = 0; m_en = 0; m_hlt = 0; m_to = 0; m_res = 0;
    end else if (abort) begin
      m_act = 0; m_fin = 0; m_en = 0;
    end else if (start && !m_act) begin
      m_act = 1; m_fin = 0; m_en = 0; m_hold = RST; m_cnt = 0; m_hlt = 0; m_to = 0; m_res = 0;
    end else if (m_act) begin
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_en = !step_mode;
      end else if (m_en) begin
        m_cnt++;
        if (cpu_halt) begin
          m_act = 0; m_fin = 1; m_en = 0; m_hlt = 1; m_res = ret_val[7:0];
        end else if (m_cnt == MAX) begin
          m_act = 0; m_fin = 1; m_en = 0; m_to = 1;
        end else m_en = !step_mode;
      end else m_en = step_req || !step_mode;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic s, input logic a, input logic sr, input logic h, input logic [15:0] rv);
    logic [45:0] act, exp;
    @(negedge clk);
    if (rst_n) begin
      exp = {(m_act ? m_hold > 0 : !m_fin), m_en, m_act, m_fin, m_hlt, m_to, m_res, 32'(m_cnt)};
      act = {cpu_rst, cpu_en, busy, done, halted, timed_out, result, cycle_count};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL model t=%0t got %h want %h", $time, act, exp);
      end
    end
    #1;
    start = s; abort = a; step_req = sr; cpu_halt = h; ret_val = rv;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask
  initial begin
    #12;
    chk("reset cpu_rst", cpu_rst, 1);
    chk("reset outs", {cpu_en, busy, done, halted, timed_out, result}, 0);
    chk("reset count", cycle_count, 0);
    @(negedge clk); #1 rst_n = 1;
    // 1: halt on 5th enabled cycle
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); chk("t1 hold1", cpu_rst, 1);
    cyc(0, 0, 0, 0, 0); chk("t1 hold2", {cpu_rst, cpu_en}, 2'b10);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, i == 5, 16'h002A);
      chk("t1 en", {cpu_rst, cpu_en}, 2'b01);
    end
    cyc(0, 0, 0, 0, 0);
    chk("t1 flags", {cpu_rst, cpu_en, busy, done, halted, timed_out}, 6'b000110);
    chk("t1 result", result, 8'h2A);
    chk("t1 count", cycle_count, 5);
    // 2: timeout after exactly MAX enabled cycles
    cyc(1, 0, 0, 0, 0); idle(2);
    for (int i = 1; i <= MAX; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t2 en", cpu_en, 1);
    end
    cyc(0, 0, 0, 0, 0);
    chk("t2 flags", {cpu_en, done, halted, timed_out}, 4'b0101);
    chk("t2 result", result, 0);
    chk("t2 count", cycle_count, 16);
    // 3: halt coinciding with budget
    cyc(1, 0, 0, 0, 0); idle(2);
    for (int i = 1; i <= MAX; i++) cyc(0, 0, 0, i == MAX, 16'h1255);
    cyc(0, 0, 0, 0, 0);
    chk("t3 flags", {done, halted, timed_out}, 3'b110);
    chk("t3 result", result, 8'h55);
    chk("t3 count", cycle_count, 16);
    // 4: single-step then switch to free-run
    step_mode = 1;
    cyc(1, 0, 0, 0, 0); idle(2);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0, 0); chk("t4 wait", cpu_en, 0);
      cyc(0, 0, 0, 0, 0); chk("t4 exec", cpu_en, 1);
      cyc(0, 0, 0, 0, 0); chk("t4 idle1", cpu_en, 0);
      cyc(0, 0, 0, 0, 0); chk("t4 idle2", cpu_en, 0);
    end
    chk("t4 count", cycle_count, 3);
    step_mode = 0;
    cyc(0, 0, 0, 0, 0); chk("t4 run1", cpu_en, 1);
    cyc(0, 0, 0, 0, 0); chk("t4 run2", cpu_en, 1);
    cyc(0, 1, 0, 0, 0);
    // 5: abort mid-run keeps count until next start
    cyc(1, 0, 0, 0, 0); idle(2); idle(7);
    cyc(0, 1, 0, 0, 0); chk("t5 pre", cycle_count, 7);
    cyc(0, 0, 0, 0, 0);
    chk("t5 idle", {cpu_rst, cpu_en, busy, done}, 4'b1000);
    chk("t5 count kept", cycle_count, 7);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); chk("t5 cleared", cycle_count, 0);
    // 6: start while busy is ignored, async reset mid-run
    cyc(1, 0, 0, 0, 0); chk("t6 hold", cpu_rst, 1);
    cyc(1, 0, 0, 0, 0); chk("t6 run", cpu_en, 1);
    cyc(0, 0, 0, 0, 0);
    chk("t6 ignored", {cpu_en, busy}, 2'b11);
    chk("t6 count", cycle_count, 1);
    idle(3);
    #2 rst_n = 0;
    #1;
    chk("t6 rst cpu_rst", cpu_rst, 1);
    chk("t6 rst outs", {cpu_en, busy, done, halted, timed_out, result}, 0);
    chk("t6 rst count", cycle_count, 0);
    #4 rst_n = 1;
    idle(2);
    chk("t6 after", {cpu_rst, busy}, 2'b10);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) step_mode = !step_mode;
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, 16'($urandom));
    end
    idle(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
